// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared BNN pipeline types and defaults
package bnn_pkg;

   localparam int BNN_DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DONE    = 2'd2
   } bnn_state_e;

endpackage

// File: rtl/bnn_result_buffer.sv
// rtl/bnn_result_buffer.sv - result store, one write port, one registered read-before-write read port
module bnn_result_buffer
   import bnn_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int DATA_W = BNN_DATA_W,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              rd_in_range;

   assign rd_in_range = (32'(rd_addr) < DEPTH);

   // next memory image and read response; reads see the pre-write contents
   always_comb begin
      mem_d      = mem_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_en;
      if (wr_en) begin
         mem_d[wr_addr] = wr_data;
      end
      if (rd_en) begin
         rd_data_d = rd_in_range ? mem_q[rd_addr] : '0;
      end
   end

   // storage is deliberately left uninitialised by reset; only the read port resets
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;

endmodule

// File: rtl/bnn_result_collector.sv
// rtl/bnn_result_collector.sv - collects last-stage results, tracks running max, signals completion
module bnn_result_collector
   import bnn_pkg::*;
#(
   parameter int TOTAL_INPUTS = 16,
   parameter int DATA_W       = BNN_DATA_W,
   parameter int IDX_W        = $clog2(TOTAL_INPUTS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              valid_out3,
   input  logic [DATA_W-1:0] result_data,
   input  logic              rd_en,
   input  logic [IDX_W-1:0]  rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic              collect_done,
   output logic [IDX_W:0]    result_count,
   output logic [DATA_W-1:0] max_score,
   output logic [IDX_W-1:0]  max_index,
   output logic              overflow_err
);

   localparam logic [IDX_W:0] TOTAL_CNT = (IDX_W + 1)'(TOTAL_INPUTS);

   bnn_state_e        state_q, state_d;
   logic [IDX_W:0]    count_q, count_d;
   logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [DATA_W-1:0] max_score_q, max_score_d;
   logic [IDX_W-1:0]  max_index_q, max_index_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              ovf_q, ovf_d;
   logic              buf_we;

   // run control: start always restarts, results only accepted while collecting
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      wr_ptr_d    = wr_ptr_q;
      max_score_d = max_score_q;
      max_index_d = max_index_q;
      ovf_d       = ovf_q;
      buf_we      = 1'b0;
      if (start) begin
         state_d     = ST_COLLECT;
         count_d     = '0;
         wr_ptr_d    = '0;
         max_score_d = '0;
         max_index_d = '0;
         ovf_d       = 1'b0;
      end else begin
         case (state_q)
            ST_COLLECT: begin
               if (valid_out3) begin
                  buf_we  = 1'b1;
                  count_d = count_q + 1'b1;
                  // strict compare so a tie keeps the earlier index
                  if ((count_q == '0) || (result_data > max_score_q)) begin
                     max_score_d = result_data;
                     max_index_d = wr_ptr_q;
                  end
                  // pointer holds on the final accept so it never wraps inside a run
                  if (count_d == TOTAL_CNT) begin
                     state_d = ST_DONE;
                  end else begin
                     wr_ptr_d = wr_ptr_q + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               if (valid_out3) begin
                  ovf_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
      busy_d = (state_d == ST_COLLECT);
      done_d = (state_d == ST_DONE);
   end

   // state, counters and status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         max_score_q <= '0;
         max_index_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         max_score_q <= max_score_d;
         max_index_q <= max_index_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         ovf_q       <= ovf_d;
      end
   end

   bnn_result_buffer #(
      .DEPTH  (TOTAL_INPUTS),
      .DATA_W (DATA_W),
      .ADDR_W (IDX_W)
   ) u_buffer (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (buf_we),
      .wr_addr  (wr_ptr_q),
      .wr_data  (result_data),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_valid (rd_valid)
   );

   assign busy         = busy_q;
   assign collect_done = done_q;
   assign result_count = count_q;
   assign max_score    = max_score_q;
   assign max_index    = max_index_q;
   assign overflow_err = ovf_q;

endmodule

// File: tb/tb_bnn_result_collector.sv
// tb/tb_bnn_result_collector.sv - scoreboard bench for bnn_result_collector
module tb_bnn_result_collector;

   localparam int T  = 16;
   localparam int T2 = 12;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       valid_out3 = 1'b0;
   logic [7:0] result_data = '0;
   logic       rd_en = 1'b0;
   logic [3:0] rd_addr = '0;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       busy;
   logic       collect_done;
   logic [4:0] result_count;
   logic [7:0] max_score;
   logic [3:0] max_index;
   logic       overflow_err;

   logic       b_start = 1'b0;
   logic       b_valid = 1'b0;
   logic [7:0] b_data = '0;
   logic       b_rd_en = 1'b0;
   logic [3:0] b_rd_addr = '0;
   logic [7:0] b_rd_data;
   logic       b_rd_valid;
   logic       b_busy;
   logic       b_done;
   logic [4:0] b_count;
   logic [7:0] b_max;
   logic [3:0] b_idx;
   logic       b_ovf;

   bnn_result_collector #(.TOTAL_INPUTS(T), .DATA_W(8)) u_dut (
      .clk(clk), .rst(rst), .start(start), .valid_out3(valid_out3),
      .result_data(result_data), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
      .collect_done(collect_done), .result_count(result_count),
      .max_score(max_score), .max_index(max_index), .overflow_err(overflow_err)
   );

   bnn_result_collector #(.TOTAL_INPUTS(T2), .DATA_W(8)) u_dut12 (
      .clk(clk), .rst(rst), .start(b_start), .valid_out3(b_valid),
      .result_data(b_data), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
      .rd_data(b_rd_data), .rd_valid(b_rd_valid), .busy(b_busy),
      .collect_done(b_done), .result_count(b_count),
      .max_score(b_max), .max_index(b_idx), .overflow_err(b_ovf)
   );

   int checks = 0;
   int errors = 0;

   // reference model: results of the current run, persistent buffer image, run mode
   int run_q[$];
   int mem_model[T];
   int mode = 0;      // 0 idle, 1 collecting, 2 done
   int ovf_m = 0;
   int exp_q[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_max();
      int m = 0;
      foreach (run_q[i]) if (i == 0 || run_q[i] > m) m = run_q[i];
      return m;
   endfunction

   function automatic int model_idx();
      int m = 0;
      int ix = 0;
      foreach (run_q[i]) if (i == 0 || run_q[i] > m) begin m = run_q[i]; ix = i; end
      return ix;
   endfunction

   task automatic model_edge(input bit r, input bit s, input bit v, input int d);
      if (r) begin
         mode = 0; run_q.delete(); ovf_m = 0;
      end else if (s) begin
         mode = 1; run_q.delete(); ovf_m = 0;
      end else if (v) begin
         if (mode == 1) begin
            mem_model[run_q.size()] = d;
            run_q.push_back(d);
            if (run_q.size() == T) mode = 2;
         end else if (mode == 2) begin
            ovf_m = 1;
         end
      end
   endtask

   task automatic check_status();
      chk("result_count", int'(result_count), run_q.size());
      chk("max_score", int'(max_score), model_max());
      chk("max_index", int'(max_index), model_idx());
      chk("busy", int'(busy), (mode == 1) ? 1 : 0);
      chk("collect_done", int'(collect_done), (mode == 2) ? 1 : 0);
      chk("overflow_err", int'(overflow_err), ovf_m);
   endtask

   task automatic step(input bit r, input bit s, input bit v, input int d,
                       input bit re, input int ra);
      rst = r; start = s; valid_out3 = v; result_data = 8'(d);
      rd_en = re; rd_addr = 4'(ra);
      if (re && !r) exp_q.push_back((ra >= T) ? 0 : mem_model[ra]);
      model_edge(r, s, v, d);
      @(posedge clk); #1;
      check_status();
   endtask

   // monitor: every read response must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rd_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_valid_spurious: got 1 expected 0 at %0t", $time);
         end else begin
            int e;
            e = exp_q.pop_front();
            chk("rd_data", int'(rd_data), e);
         end
      end
   end

   initial begin
      // reset state
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      chk("rd_data_reset", int'(rd_data), 0);
      chk("rd_valid_reset", int'(rd_valid), 0);
      step(0, 0, 1, 77, 0, 0);                  // ignored in idle

      // full run 10..160
      step(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < T; i++) step(0, 0, 1, (i + 1) * 10, 0, 0);
      chk("done_after_16", int'(collect_done), 1);
      chk("max_160", int'(max_score), 160);
      chk("idx_15", int'(max_index), 15);
      step(0, 0, 0, 0, 1, 3);
      step(0, 0, 0, 0, 0, 0);

      // overflow after done, start clears it
      step(0, 0, 1, 255, 0, 0);
      chk("ovf_set", int'(overflow_err), 1);
      step(0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      chk("ovf_cleared", int'(overflow_err), 0);

      // ties with gaps: first 90 keeps the index
      step(0, 0, 1, 5, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 90, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 90, 0, 0);
      step(0, 0, 1, 7, 0, 0);
      chk("tie_idx", int'(max_index), 1);
      for (int i = 0; i < T - 4; i++) step(0, 0, ($urandom_range(0, 1) == 1), $urandom_range(0, 89), 0, 0);
      while (mode == 1) step(0, 0, 1, $urandom_range(0, 89), 0, 0);

      // start together with a result at count 5
      step(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 30 + i, 0, 0);
      step(0, 1, 1, 222, 0, 0);
      chk("restart_count", int'(result_count), 0);
      step(0, 0, 1, 44, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0);

      // reset mid-run at count 7, then valid without start is ignored
      for (int i = 0; i < 6; i++) step(0, 0, 1, 100 + i, 0, 0);
      step(0, 0, 0, 0, 1, 2);
      step(1, 0, 0, 0, 0, 0);
      chk("rd_data_midrst", int'(rd_data), 0);
      chk("rd_valid_midrst", int'(rd_valid), 0);
      step(0, 0, 1, 9, 0, 0);

      // read-before-write at the index being written
      step(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 60 + i, 0, 0);
      step(0, 0, 1, 200, 1, 3);
      step(0, 0, 0, 0, 1, 3);
      step(0, 0, 0, 0, 0, 0);

      // randomized traffic
      for (int c = 0; c < 600; c++) begin
         bit r, s, v, re;
         r  = ($urandom_range(0, 199) == 0);
         s  = ($urandom_range(0, 99) < 3);
         v  = ($urandom_range(0, 99) < 60);
         re = ($urandom_range(0, 99) < 40);
         step(r, s, v, $urandom_range(0, 255), re, $urandom_range(0, T - 1));
      end
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("reads_drained", exp_q.size(), 0);

      // 12-entry instance: out-of-range readback
      b_start = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0;
      for (int i = 0; i < T2; i++) begin
         b_valid = 1'b1; b_data = 8'(i * 3 + 1);
         @(posedge clk); #1;
      end
      b_valid = 1'b0;
      chk("b_done", int'(b_done), 1);
      chk("b_count", int'(b_count), T2);
      chk("b_max", int'(b_max), 34);
      chk("b_idx", int'(b_idx), 11);
      b_rd_en = 1'b1; b_rd_addr = 4'd11;
      @(posedge clk); #1;
      chk("b_rd_11", int'(b_rd_data), 34);
      b_rd_addr = 4'd13;
      @(posedge clk); #1;
      chk("b_rd_oor_data", int'(b_rd_data), 0);
      chk("b_rd_oor_valid", int'(b_rd_valid), 1);
      b_rd_en = 1'b0;
      @(posedge clk); #1;
      chk("b_rd_valid_idle", int'(b_rd_valid), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bnn_result_collector.md
# bnn_result_collector

Sink end of the streaming BNN pipeline: captures each result leaving the last layer stage (`valid_out3` plus its score), stores it at the next sequential index in an on-chip result buffer, and tracks the running maximum score and its index. It asserts `collect_done` once exactly `TOTAL_INPUTS` results have been received, and offers a one-cycle-latency readback port for the host or test logic. It sits after layer 3 and mirrors the issuing pipeline controller: the controller counts inputs out, this block counts results back in.

## Interface
- `TOTAL_INPUTS`, 16: results expected per run; must be ≥2.
- `DATA_W`, 8: width of one result score (unsigned popcount).
- `IDX_W`, `$clog2(TOTAL_INPUTS)`: derived; index width.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin/restart a collection run (single-cycle pulse).
- `valid_out3`  in  1  last pipeline stage has a result this cycle.
- `result_data`  in  DATA_W  score accompanying `valid_out3`.
- `rd_en`  in  1  readback request.
- `rd_addr`  in  IDX_W  readback index.
- `rd_data`  out  DATA_W  readback value; reset 0.
- `rd_valid`  out  1  `rd_data` valid; reset 0.
- `busy`  out  1  FSM in COLLECT; reset 0.
- `collect_done`  out  1  all results captured; reset 0.
- `result_count`  out  IDX_W+1  results captured this run; reset 0.
- `max_score`  out  DATA_W  largest score this run; reset 0.
- `max_index`  out  IDX_W  index of `max_score`; reset 0.
- `overflow_err`  out  1  sticky, a result arrived in DONE; reset 0.

## Operation
- FSM states: IDLE, COLLECT, DONE. Reset → IDLE.
- IDLE: `start` → COLLECT; clears count, write pointer, max, done, error. `valid_out3` ignored.
- COLLECT: each cycle with `valid_out3`=1, write `result_data` to `buf[wr_ptr]`, increment `wr_ptr` and `result_count`.
- Max tracking: update when count is 0 (first result) or `result_data` > `max_score` (strict); ties keep the earlier index.
- When the accepted result makes count = TOTAL_INPUTS → DONE and set `collect_done`.
- DONE: `valid_out3`=1 sets `overflow_err`; data is not written, count is not incremented. `start` → COLLECT with full clear.
- `start` in COLLECT restarts the run (full clear). If `start` and `valid_out3` occur in the same cycle, `start` wins and that result is dropped.
- `start` also clears `overflow_err`. Only `rst` and `start` clear it.
- Buffer contents are not cleared by `start` or `rst`. Readback is meaningful only for indices below `result_count`.
- Readback works in every state. `rd_addr` ≥ TOTAL_INPUTS returns 0 with `rd_valid`=1.
- Arithmetic: `result_count` saturates at TOTAL_INPUTS. The write pointer never wraps within a run.

## Timing
- Write: buffer entry, `result_count`, `max_*` update at the edge sampling `valid_out3`; visible the next cycle.
- `collect_done` and `busy` are registered. `collect_done` rises the cycle after the TOTAL_INPUTS-th accept, with `busy` falling in the same cycle.
- Readback: `rd_en` at edge N → `rd_data` and `rd_valid` at N+1. `rd_valid` is 0 in cycles without a prior `rd_en`.
- Read and write to the same address in the same cycle returns the old data (read-before-write).
- `rst` mid-run: next cycle all outputs are at reset values and the FSM is in IDLE.
- Back-to-back `valid_out3` every cycle is sustained; there is no backpressure.

## Structure
- Shared package `bnn_pkg`: FSM state enum (IDLE/COLLECT/DONE) and default `DATA_W`, shared with the pipeline controller.
- One sub-module, `bnn_result_buffer`: single write port and single synchronous read port, TOTAL_INPUTS×DATA_W, read-before-write.
- FSM, counters and max tracker live in the top level.

## Test plan
- Reset, `start`, 16 consecutive results 10,20,…,160 → `collect_done`=1 one cycle after the 16th; `result_count`=16; `max_score`=160, `max_index`=15; read addr 3 → 40.
- Scores 5,90,90,7 with gaps between valids (TOTAL_INPUTS=4) → `max_score`=90, `max_index`=1 (tie keeps first); `busy` stays high across the gaps.
- After done, one extra `valid_out3` with 0xFF → `overflow_err`=1, `result_count` stays 16, `max_score` unchanged; next `start` clears the error.
- `start` together with `valid_out3` at count 5 → count reads 0 the next cycle; following result lands at index 0.
- `rst` at count 7 → all outputs 0 and FSM in IDLE the next cycle; `valid_out3` without `start` is ignored.
- `rd_en` with `rd_addr`=index being written that cycle → old data. Out-of-range read is not reachable with TOTAL_INPUTS=16 (IDX_W=4); bench it with TOTAL_INPUTS=12, `rd_addr`=13 → `rd_data`=0, `rd_valid`=1.
